// File: rtl/hazard_unit_pkg.sv
// Shared types for the RV32 pipeline hazard controller: the shadow slot that
// tracks the destination of the instruction in EX or MEM, and the controller
// FSM state.
package hazard_unit_pkg;

    // Architectural register address width of RV32 (x0..x31).
    localparam int RV_REG_ADDR_W = 5;

    // Default width of the stall/flush performance counters.
    localparam int HZ_CNT_W = 32;

    // Destination information of one in-flight instruction.
    typedef struct packed {
        logic                     valid;
        logic [RV_REG_ADDR_W-1:0] rd;
        logic                     regwr;
        logic                     isload;
    } hz_slot_t;

    // RUN      : normal flow, all hazard rules evaluated.
    // LU_STALL : the cycle after a load-use bubble; the load now sits in MEM.
    // MEM_WAIT : whole pipe held while data memory is busy.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_unit_fwd_cmp.sv
// hz_fwd_cmp: decides whether one ID source operand reads the register that
// one shadow slot is going to write. Purely combinational.
module hz_fwd_cmp #(
    parameter int ADDR_W = 5
) (
    input  logic              src_used_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic              slot_valid_i,
    input  logic [ADDR_W-1:0] slot_rd_i,
    input  logic              slot_regwr_i,
    output logic              match_o
);

    logic slot_writes_rd;

    // x0 is hardwired to zero, so a slot targeting it never produces a value
    always_comb begin
        slot_writes_rd = slot_valid_i & slot_regwr_i & (slot_rd_i != '0);
        match_o        = src_used_i & slot_writes_rd & (slot_rd_i == src_addr_i);
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: hazard controller for the 5-stage RV32 datapath.
// Tracks the destinations of the instructions in EX and MEM, produces the
// registered EX forwarding enables, and controls stall, load-use bubble and
// branch flush. Two saturating counters report stall cycles and flushes.
//
// Hold semantics: oStall=1 freezes IF/ID/EX/MEM and this unit's shadow state
// for that cycle; oHoldFront=1 freezes only PC and IF/ID while EX receives
// a bubble (oBubbleEX). Nothing advances in the cycle oStall is high, and
// a taken branch is only accepted in a cycle where oStall is low.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = RV_REG_ADDR_W,
    parameter int CNT_W      = HZ_CNT_W
) (
    input  logic                  iClk,
    input  logic                  nRst,
    input  logic                  iIdValid,
    input  logic [REG_ADDR_W-1:0] iIdRs1,
    input  logic [REG_ADDR_W-1:0] iIdRs2,
    input  logic                  iIdRs1Used,
    input  logic                  iIdRs2Used,
    input  logic [REG_ADDR_W-1:0] iIdRd,
    input  logic                  iIdRegWr,
    input  logic                  iIdIsLoad,
    input  logic                  iBranchTaken,
    input  logic                  iMemBusy,
    output logic                  oStall,
    output logic                  oHoldFront,
    output logic                  oBubbleEX,
    output logic                  oFlush,
    output logic                  oFwExS1_en,
    output logic                  oFwExS2_en,
    output logic                  oFwMeS1_en,
    output logic                  oFwMeS2_en,
    output logic [CNT_W-1:0]      oStallCnt,
    output logic [CNT_W-1:0]      oFlushCnt,
    output logic [1:0]            oDbgState
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    hz_state_e  state_q, state_d;
    hz_slot_t   ex_slot_q, ex_slot_d;
    hz_slot_t   me_slot_q, me_slot_d;

    logic       fw_ex_s1_q, fw_ex_s1_d;
    logic       fw_ex_s2_q, fw_ex_s2_d;
    logic       fw_me_s1_q, fw_me_s1_d;
    logic       fw_me_s2_q, fw_me_s2_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // ------------------------------------------------------------------
    // Source/slot comparisons
    // ------------------------------------------------------------------
    logic src1_used;
    logic src2_used;
    logic ex_hit_s1;
    logic ex_hit_s2;
    logic me_hit_s1;
    logic me_hit_s2;
    logic fw_me_s1;
    logic fw_me_s2;
    logic lu_haz;

    // A source only counts when ID holds a real instruction that reads it
    always_comb begin
        src1_used = iIdValid & iIdRs1Used;
        src2_used = iIdValid & iIdRs2Used;
    end

    hz_fwd_cmp #(.ADDR_W(REG_ADDR_W)) u_cmp_ex_s1 (
        .src_used_i   (src1_used),
        .src_addr_i   (iIdRs1),
        .slot_valid_i (ex_slot_q.valid),
        .slot_rd_i    (ex_slot_q.rd),
        .slot_regwr_i (ex_slot_q.regwr),
        .match_o      (ex_hit_s1)
    );

    hz_fwd_cmp #(.ADDR_W(REG_ADDR_W)) u_cmp_ex_s2 (
        .src_used_i   (src2_used),
        .src_addr_i   (iIdRs2),
        .slot_valid_i (ex_slot_q.valid),
        .slot_rd_i    (ex_slot_q.rd),
        .slot_regwr_i (ex_slot_q.regwr),
        .match_o      (ex_hit_s2)
    );

    hz_fwd_cmp #(.ADDR_W(REG_ADDR_W)) u_cmp_me_s1 (
        .src_used_i   (src1_used),
        .src_addr_i   (iIdRs1),
        .slot_valid_i (me_slot_q.valid),
        .slot_rd_i    (me_slot_q.rd),
        .slot_regwr_i (me_slot_q.regwr),
        .match_o      (me_hit_s1)
    );

    hz_fwd_cmp #(.ADDR_W(REG_ADDR_W)) u_cmp_me_s2 (
        .src_used_i   (src2_used),
        .src_addr_i   (iIdRs2),
        .slot_valid_i (me_slot_q.valid),
        .slot_rd_i    (me_slot_q.rd),
        .slot_regwr_i (me_slot_q.regwr),
        .match_o      (me_hit_s2)
    );

    // Youngest producer wins: a MEM match is dropped when EX also matches.
    // A load in EX cannot forward yet, which is the load-use hazard.
    always_comb begin
        fw_me_s1 = me_hit_s1 & ~ex_hit_s1;
        fw_me_s2 = me_hit_s2 & ~ex_hit_s2;
        lu_haz   = ex_slot_q.isload & (ex_hit_s1 | ex_hit_s2);
    end

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    logic stall_c;
    logic hold_c;
    logic bubble_c;
    logic flush_c;
    logic run_rules;

    // Next state and hazard controls; MEM_WAIT drops back to the RUN rules
    // in the same cycle the memory becomes ready, and LU_STALL always does
    always_comb begin
        state_d   = state_q;
        stall_c   = 1'b0;
        hold_c    = 1'b0;
        bubble_c  = 1'b0;
        flush_c   = 1'b0;
        run_rules = 1'b0;

        case (state_q)
            MEM_WAIT: begin
                if (iMemBusy) begin
                    stall_c = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            default: begin
                run_rules = 1'b1;
            end
        endcase

        if (run_rules) begin
            if (iMemBusy) begin
                stall_c = 1'b1;
                state_d = MEM_WAIT;
            end else if (iBranchTaken) begin
                // The dependent instruction is killed, so no load-use stall
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                state_d  = RUN;
            end else if (lu_haz) begin
                hold_c   = 1'b1;
                bubble_c = 1'b1;
                state_d  = LU_STALL;
            end else begin
                state_d  = RUN;
            end
        end
    end

    // FSM state register
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow slots and registered forwarding enables
    // ------------------------------------------------------------------
    // Advance the shadow pipe unless the whole pipe is stalled
    always_comb begin
        me_slot_d  = me_slot_q;
        ex_slot_d  = ex_slot_q;
        fw_ex_s1_d = fw_ex_s1_q;
        fw_ex_s2_d = fw_ex_s2_q;
        fw_me_s1_d = fw_me_s1_q;
        fw_me_s2_d = fw_me_s2_q;

        if (!stall_c) begin
            me_slot_d = ex_slot_q;
            ex_slot_d = '0;
            if (!(bubble_c | flush_c) && iIdValid) begin
                ex_slot_d.valid  = 1'b1;
                ex_slot_d.rd     = iIdRd;
                ex_slot_d.regwr  = iIdRegWr;
                ex_slot_d.isload = iIdIsLoad;
            end

            if (bubble_c | flush_c) begin
                fw_ex_s1_d = 1'b0;
                fw_ex_s2_d = 1'b0;
                fw_me_s1_d = 1'b0;
                fw_me_s2_d = 1'b0;
            end else begin
                fw_ex_s1_d = ex_hit_s1;
                fw_ex_s2_d = ex_hit_s2;
                fw_me_s1_d = fw_me_s1;
                fw_me_s2_d = fw_me_s2;
            end
        end
    end

    // Shadow slot and forwarding-enable registers
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            ex_slot_q  <= '0;
            me_slot_q  <= '0;
            fw_ex_s1_q <= 1'b0;
            fw_ex_s2_q <= 1'b0;
            fw_me_s1_q <= 1'b0;
            fw_me_s2_q <= 1'b0;
        end else begin
            ex_slot_q  <= ex_slot_d;
            me_slot_q  <= me_slot_d;
            fw_ex_s1_q <= fw_ex_s1_d;
            fw_ex_s2_q <= fw_ex_s2_d;
            fw_me_s1_q <= fw_me_s1_d;
            fw_me_s2_q <= fw_me_s2_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
    // Count held cycles and accepted flushes, sticking at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_c | hold_c) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Combinational controls are forced low while reset is asserted so that
    // every output reads zero immediately, even if iMemBusy is high
    always_comb begin
        oStall     = stall_c  & nRst;
        oHoldFront = hold_c   & nRst;
        oBubbleEX  = bubble_c & nRst;
        oFlush     = flush_c  & nRst;
        oFwExS1_en = fw_ex_s1_q;
        oFwExS2_en = fw_ex_s2_q;
        oFwMeS1_en = fw_me_s1_q;
        oFwMeS2_en = fw_me_s2_q;
        oStallCnt  = stall_cnt_q;
        oFlushCnt  = flush_cnt_q;
        oDbgState  = state_q;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, reset-during-stall sequence,
// randomized traffic against a pipeline-level reference model, and counter
// saturation with a narrow counter width.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int AW      = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic iClk = 1'b0;
    logic nRst;
    always #5 iClk = ~iClk;

    logic          iIdValid, iIdRs1Used, iIdRs2Used, iIdRegWr, iIdIsLoad;
    logic [AW-1:0] iIdRs1, iIdRs2, iIdRd;
    logic          iBranchTaken, iMemBusy;
    logic          oStall, oHoldFront, oBubbleEX, oFlush;
    logic          oFwExS1_en, oFwExS2_en, oFwMeS1_en, oFwMeS2_en;
    logic [CW-1:0] oStallCnt, oFlushCnt;
    logic [1:0]    oDbgState;

    hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .iClk(iClk), .nRst(nRst), .iIdValid(iIdValid),
        .iIdRs1(iIdRs1), .iIdRs2(iIdRs2),
        .iIdRs1Used(iIdRs1Used), .iIdRs2Used(iIdRs2Used),
        .iIdRd(iIdRd), .iIdRegWr(iIdRegWr), .iIdIsLoad(iIdIsLoad),
        .iBranchTaken(iBranchTaken), .iMemBusy(iMemBusy),
        .oStall(oStall), .oHoldFront(oHoldFront), .oBubbleEX(oBubbleEX),
        .oFlush(oFlush),
        .oFwExS1_en(oFwExS1_en), .oFwExS2_en(oFwExS2_en),
        .oFwMeS1_en(oFwMeS1_en), .oFwMeS2_en(oFwMeS2_en),
        .oStallCnt(oStallCnt), .oFlushCnt(oFlushCnt), .oDbgState(oDbgState)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- stimulus / vector types ----------------
    typedef struct packed {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
        bit       br;
        bit       busy;
    } stim_t;

    typedef struct packed {
        stim_t    s;
        bit       st;
        bit       ho;
        bit       bu;
        bit       fl;
        bit [3:0] fw;   // {ExS1, ExS2, MeS1, MeS2}
        int       sc;
        int       fc;
        int       stt;
    } vec_t;

    function automatic stim_t ins(bit v, int rd, int rs1, int rs2, bit u2,
                                  bit ld, bit br, bit busy);
        stim_t r;
        r      = '0;
        r.v    = v;
        r.rd   = 5'(rd);
        r.rs1  = 5'(rs1);
        r.rs2  = 5'(rs2);
        r.u1   = v;
        r.u2   = u2;
        r.wr   = v;
        r.ld   = ld;
        r.br   = br;
        r.busy = busy;
        return r;
    endfunction

    function automatic vec_t mkv(stim_t s, bit st, bit ho, bit bu, bit fl,
                                 bit [3:0] fw, int sc, int fc, int stt);
        vec_t r;
        r.s = s; r.st = st; r.ho = ho; r.bu = bu; r.fl = fl;
        r.fw = fw; r.sc = sc; r.fc = fc; r.stt = stt;
        return r;
    endfunction

    // ---------------- reference model ----------------
    // The model holds the instruction records sitting in EX and MEM and
    // derives every control from the hazard rules directly.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t    m_ex, m_me;
    bit [3:0]  m_fw;
    int        m_scnt, m_fcnt;
    hz_state_e m_state;

    task automatic model_reset();
        m_ex    = '{0, 0, 0, 0};
        m_me    = '{0, 0, 0, 0};
        m_fw    = 4'b0;
        m_scnt  = 0;
        m_fcnt  = 0;
        m_state = RUN;
    endtask

    function automatic bit produces(instr_t p, bit used, int rs);
        return used && p.v && p.wr && (p.rd != 0) && (p.rd == rs);
    endfunction

    task automatic model_comb(input stim_t s, output bit st, output bit ho,
                              output bit bu, output bit fl);
        bit lu;
        lu = m_ex.ld && (produces(m_ex, s.v && s.u1, int'(s.rs1)) ||
                         produces(m_ex, s.v && s.u2, int'(s.rs2)));
        st = s.busy;
        fl = !s.busy && s.br;
        bu = !s.busy && (s.br || lu);
        ho = !s.busy && !s.br && lu;
    endtask

    task automatic model_step(input stim_t s);
        bit st, ho, bu, fl, e1, e2, me1, me2;
        model_comb(s, st, ho, bu, fl);
        if (!st) begin
            e1  = produces(m_ex, s.v && s.u1, int'(s.rs1));
            e2  = produces(m_ex, s.v && s.u2, int'(s.rs2));
            me1 = !e1 && produces(m_me, s.v && s.u1, int'(s.rs1));
            me2 = !e2 && produces(m_me, s.v && s.u2, int'(s.rs2));
            m_me = m_ex;
            if (bu || !s.v) m_ex = '{0, 0, 0, 0};
            else            m_ex = '{1, int'(s.rd), s.wr, s.ld};
            m_fw = bu ? 4'b0 : {e1, e2, me1, me2};
        end
        if ((st || ho) && m_scnt < CNT_MAX) m_scnt++;
        if (fl && m_fcnt < CNT_MAX) m_fcnt++;
        m_state = st ? MEM_WAIT : (ho ? LU_STALL : RUN);
    endtask

    // ---------------- driver / checker ----------------
    task automatic drive(input stim_t s);
        iIdValid     = s.v;
        iIdRs1       = s.rs1;
        iIdRs2       = s.rs2;
        iIdRs1Used   = s.u1;
        iIdRs2Used   = s.u2;
        iIdRd        = s.rd;
        iIdRegWr     = s.wr;
        iIdIsLoad    = s.ld;
        iBranchTaken = s.br;
        iMemBusy     = s.busy;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag, input bit st, input bit ho,
                               input bit bu, input bit fl, input bit [3:0] fw,
                               input int sc, input int fc, input int stt);
        check({tag, ".stall"},     32'(oStall),     32'(st));
        check({tag, ".hold"},      32'(oHoldFront), 32'(ho));
        check({tag, ".bubble"},    32'(oBubbleEX),  32'(bu));
        check({tag, ".flush"},     32'(oFlush),     32'(fl));
        check({tag, ".fw"},
              32'({oFwExS1_en, oFwExS2_en, oFwMeS1_en, oFwMeS2_en}), 32'(fw));
        check({tag, ".stall_cnt"}, 32'(oStallCnt),  sc);
        check({tag, ".flush_cnt"}, 32'(oFlushCnt),  fc);
        check({tag, ".state"},     32'(oDbgState),  stt);
    endtask

    task automatic run_model_cycle(input stim_t s, input string tag);
        bit st, ho, bu, fl;
        @(negedge iClk);
        drive(s);
        #2;
        model_comb(s, st, ho, bu, fl);
        compare_all(tag, st, ho, bu, fl, m_fw, m_scnt, m_fcnt, int'(m_state));
        @(posedge iClk);
        model_step(s);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge iClk);
        drive(v.s);
        #2;
        compare_all($sformatf("vec%0d", idx), v.st, v.ho, v.bu, v.fl, v.fw,
                    v.sc, v.fc, v.stt);
        @(posedge iClk);
        model_step(v.s);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t tbl[18];

    initial begin
        stim_t idle;
        stim_t s;
        idle = '0;

        // Reset state
        nRst = 1'b0;
        drive(idle);
        model_reset();
        #12;
        compare_all("reset", 0, 0, 0, 0, 4'b0, 0, 0, int'(RUN));
        @(negedge iClk);
        nRst = 1'b1;

        // Directed table: each row's fw/counters/state are what that cycle
        // observes, i.e. the result of the decisions made in earlier rows.
        tbl[0]  = mkv(ins(1, 5, 1, 2, 1, 0, 0, 0),   0,0,0,0, 4'b0000, 0,0, int'(RUN));      // add x5,x1,x2
        tbl[1]  = mkv(ins(1, 6, 5, 1, 1, 0, 0, 0),   0,0,0,0, 4'b0000, 0,0, int'(RUN));      // add x6,x5,x1
        tbl[2]  = mkv(ins(1, 7, 1, 2, 1, 0, 0, 0),   0,0,0,0, 4'b1000, 0,0, int'(RUN));      // add x7 (a); x6 in EX: FwEx1
        tbl[3]  = mkv(ins(1, 7, 3, 4, 1, 0, 0, 0),   0,0,0,0, 4'b0000, 0,0, int'(RUN));      // add x7 (b)
        tbl[4]  = mkv(ins(1, 8, 1, 7, 1, 0, 0, 0),   0,0,0,0, 4'b0000, 0,0, int'(RUN));      // add x8,x1,x7
        tbl[5]  = mkv(ins(1, 3, 9, 8, 0, 1, 0, 0),   0,0,0,0, 4'b0100, 0,0, int'(RUN));      // lw x3; x8 in EX: FwEx2 only
        tbl[6]  = mkv(ins(1, 4, 3, 2, 1, 0, 0, 0),   0,1,1,0, 4'b0000, 0,0, int'(RUN));      // add x4,x3,x2: load-use
        tbl[7]  = mkv(ins(1, 4, 3, 2, 1, 0, 0, 0),   0,0,0,0, 4'b0000, 1,0, int'(LU_STALL)); // re-presented
        tbl[8]  = mkv(ins(1, 0, 1, 0, 0, 1, 0, 0),   0,0,0,0, 4'b0010, 1,0, int'(RUN));      // lw x0; add in EX: FwMe1
        tbl[9]  = mkv(ins(1, 10, 0, 0, 1, 0, 0, 0),  0,0,0,0, 4'b0000, 1,0, int'(RUN));      // use x0: nothing
        tbl[10] = mkv(ins(1, 11, 1, 0, 0, 1, 0, 0),  0,0,0,0, 4'b0000, 1,0, int'(RUN));      // lw x11
        tbl[11] = mkv(ins(1, 12, 11, 11, 1, 0, 1, 0),0,0,1,1, 4'b0000, 1,0, int'(RUN));      // branch + load-use
        tbl[12] = mkv(ins(1, 13, 11, 1, 1, 0, 0, 0), 0,0,0,0, 4'b0000, 1,1, int'(RUN));      // add x13,x11,x1
        tbl[13] = mkv(ins(1, 14, 13, 13, 1, 0, 1, 1),1,0,0,0, 4'b0010, 1,1, int'(RUN));      // busy + branch
        tbl[14] = mkv(ins(1, 14, 13, 13, 1, 0, 1, 1),1,0,0,0, 4'b0010, 2,1, int'(MEM_WAIT));
        tbl[15] = mkv(ins(1, 14, 13, 13, 1, 0, 1, 1),1,0,0,0, 4'b0010, 3,1, int'(MEM_WAIT));
        tbl[16] = mkv(ins(1, 14, 13, 13, 1, 0, 1, 0),0,0,1,1, 4'b0010, 4,1, int'(MEM_WAIT)); // busy drops: flush
        tbl[17] = mkv(ins(0, 0, 0, 0, 0, 0, 0, 0),   0,0,0,0, 4'b0000, 4,2, int'(RUN));
        for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

        // Reset pulled during LU_STALL, with iMemBusy high at the same time
        run_model_cycle(ins(1, 3, 9, 0, 0, 1, 0, 0), "lu_load");
        run_model_cycle(ins(1, 4, 3, 2, 1, 0, 0, 0), "lu_use");
        @(negedge iClk);
        check("pre_rst_state", 32'(oDbgState), 32'(int'(LU_STALL)));
        drive(ins(1, 4, 3, 2, 1, 0, 0, 1));
        #1;
        nRst = 1'b0;
        #1;
        compare_all("rst_mid", 0, 0, 0, 0, 4'b0, 0, 0, int'(RUN));
        @(posedge iClk);
        @(negedge iClk);
        drive(idle);
        nRst = 1'b1;
        model_reset();
        #2;
        compare_all("post_rst", 0, 0, 0, 0, 4'b0, 0, 0, int'(RUN));
        run_model_cycle(idle, "post_rst_run");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            s      = '0;
            s.v    = ($urandom_range(0, 9) != 0);
            s.rs1  = 5'($urandom_range(0, 7));
            s.rs2  = 5'($urandom_range(0, 7));
            s.u1   = ($urandom_range(0, 4) != 0);
            s.u2   = ($urandom_range(0, 4) != 0);
            s.rd   = 5'($urandom_range(0, 7));
            s.wr   = s.v && ($urandom_range(0, 4) != 0);
            s.ld   = ($urandom_range(0, 2) == 0);
            s.br   = ($urandom_range(0, 7) == 0);
            s.busy = ($urandom_range(0, 5) == 0);
            run_model_cycle(s, $sformatf("rnd%0d", i));
        end

        // Long memory stall: stall counter must stick at all-ones
        for (int i = 0; i < 20; i++) begin
            s      = ins(1, $urandom_range(1, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), 1, 0, 1, 1);
            run_model_cycle(s, $sformatf("busy%0d", i));
        end
        @(negedge iClk);
        drive(idle);
        #2;
        check("stall_cnt_sat", 32'(oStallCnt), CNT_MAX);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
